alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- EX/MEM boundary register directly downstream of the 16-bit ALU.
- Captures the ALU Output, flag_zero and flag_negative, together with the instruction's write-back and memory controls.
- Holds the architectural Z/N flag register, resolves conditional branches, and squashes wrong-path slots after a taken branch.
- Keeps a saturating retired-instruction counter.

Parameters:
WIDTH, 16, datapath width; matches the ALU operand and result width
REG_ADDR_W, 3, destination register index width
KILL_SLOTS, 1, number of non-stalled load cycles squashed after a taken branch (1..3)

Ports:
EN  input  1  clock; rising edge; same clock that drives the ALU
rst_n  input  1  reset; asynchronous, active-low
ex_valid  input  1  incoming slot holds a real instruction
ex_result  input  WIDTH  ALU Output
ex_zero  input  1  ALU flag_zero
ex_negative  input  1  ALU flag_negative
ex_rd  input  REG_ADDR_W  destination register
ex_reg_write  input  1  write-back enable
ex_mem_read  input  1  load
ex_mem_write  input  1  store
ex_store_data  input  WIDTH  store data
ex_set_flags  input  1  instruction updates Z/N
ex_branch  input  1  conditional branch
ex_branch_cond  input  2  00 EQ (zero); 01 NE (!zero); 10 LT (negative); 11 GT (!zero & !negative)
ex_branch_target  input  WIDTH  branch destination
stall  input  1  hold all state
flush  input  1  insert bubble
mem_valid, mem_reg_write, mem_mem_read, mem_mem_write  output  1 each  registered controls
mem_result, mem_store_data  output  WIDTH  registered data
mem_rd  output  REG_ADDR_W  registered destination
flag_z, flag_n  output  1 each  architectural flags
branch_taken  output  1  one-cycle pulse
branch_target  output  WIDTH  valid while branch_taken=1
retired_count  output  16  saturating count of accepted instructions

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0; kill_cnt is 0.
- Per-edge priority: reset > flush > stall > load.
- Flush:
  - mem_valid and all mem_* controls become 0; branch_taken becomes 0; kill_cnt becomes 0.
  - mem_result, mem_store_data, mem_rd, flags, retired_count and branch_target hold.
- Stall:
  - All registers hold, except branch_taken, which becomes 0.
  - A taken-branch pulse is never repeated while stalled.
- Load, with accept = ex_valid & (kill_cnt==0):
  - mem_result, mem_store_data, mem_rd are always captured.
  - mem_valid <= accept.
  - mem_reg_write, mem_mem_read, mem_mem_write <= the ex_* value AND accept.
  - If accept & ex_set_flags: flag_z <= ex_zero, flag_n <= ex_negative; otherwise the flags hold.
  - Branch condition is evaluated on the incoming ex_zero/ex_negative, not on the stored flags.
  - taken = accept & ex_branch & cond. branch_taken <= taken; branch_target <= ex_branch_target when taken.
  - kill_cnt: if taken, load KILL_SLOTS; else if kill_cnt>0, decrement by 1 (even when ex_valid=0); else 0.
  - retired_count increments by 1 when accept is true; it saturates at 16'hFFFF.
- Latency: one cycle from the EX inputs to all mem_*, flag and branch outputs.
- Killed slots behave exactly as bubbles: no flag update, no branch, no count.
- Stall and flush asserted together: flush wins.
- A mid-operation reset clears any pending kill window and any branch pulse.

Test Plan:
- Reset: rst_n=0 asynchronously, between edges -> all outputs 0 immediately, before the next edge.
- Load: ex_result=117 (16+101), ex_rd=3, ex_reg_write=1, ex_set_flags=1, zero=0, neg=0 -> next edge: mem_result=117, mem_rd=3, mem_valid=1, flag_z=0, flag_n=0, retired_count=1.
- Taken branch: ex_result=0, zero=1, ex_branch=1, cond=00, target=16'h0040, KILL_SLOTS=1 -> branch_taken=1 for exactly one cycle with branch_target=16'h0040. The following valid ADD (result 29) yields mem_valid=0, flags unchanged, count unchanged. The ADD after that is accepted.
- GT vs LT on 44-15=29: cond=11 -> taken. Same instruction with zero=0, neg=1, cond=11 -> not taken; with cond=10 -> taken.
- Stall 3 cycles with a taken branch loaded -> branch_taken high only in the first cycle; mem_* held for all 3 cycles; kill_cnt not decremented during the stall.
- Flush with stall together, plus saturation: flush with stall=1 and a pending kill -> mem_valid=0, kill_cnt=0, next valid instruction accepted. Preset retired_count to FFFE, then two accepts -> FFFF, FFFF.

Source files
------------

// File: rtl/alu_result_stage.sv
// EX/MEM boundary register behind the 16-bit ALU. Captures the ALU result
// and instruction controls, holds the architectural Z/N flags, resolves
// conditional branches, squashes wrong-path slots after a taken branch and
// keeps a saturating count of retired instructions.
module alu_result_stage #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3,
  parameter int KILL_SLOTS = 1
) (
  input  logic                  EN,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [WIDTH-1:0]      ex_result,
  input  logic                  ex_zero,
  input  logic                  ex_negative,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [WIDTH-1:0]      ex_store_data,
  input  logic                  ex_set_flags,
  input  logic                  ex_branch,
  input  logic [1:0]            ex_branch_cond,
  input  logic [WIDTH-1:0]      ex_branch_target,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  mem_valid,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic [WIDTH-1:0]      mem_result,
  output logic [WIDTH-1:0]      mem_store_data,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  branch_taken,
  output logic [WIDTH-1:0]      branch_target,
  output logic [15:0]           retired_count
);

  localparam logic [1:0] KILL_INIT = 2'(KILL_SLOTS);

  logic                  r_valid;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [WIDTH-1:0]      r_result;
  logic [WIDTH-1:0]      r_store_data;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_flag_z;
  logic                  r_flag_n;
  logic                  r_branch_taken;
  logic [WIDTH-1:0]      r_branch_target;
  logic [15:0]           r_retired;
  logic [1:0]            r_kill_cnt;

  logic w_cond;
  logic w_accept;
  logic w_taken;

  // Branch condition from the incoming ALU flags, plus accept/taken qualifiers
  always_comb begin
    w_cond = 1'b0;
    unique case (ex_branch_cond)
      2'b00:   w_cond = ex_zero;
      2'b01:   w_cond = !ex_zero;
      2'b10:   w_cond = ex_negative;
      2'b11:   w_cond = !ex_zero && !ex_negative;
      default: w_cond = 1'b0;
    endcase
    w_accept = ex_valid && (r_kill_cnt == 2'd0);
    w_taken  = w_accept && ex_branch && w_cond;
  end

  // Stage register: reset > flush > stall > load
  always_ff @(posedge EN or negedge rst_n) begin
    if (!rst_n) begin
      r_valid         <= 1'b0;
      r_reg_write     <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_result        <= '0;
      r_store_data    <= '0;
      r_rd            <= '0;
      r_flag_z        <= 1'b0;
      r_flag_n        <= 1'b0;
      r_branch_taken  <= 1'b0;
      r_branch_target <= '0;
      r_retired       <= '0;
      r_kill_cnt      <= 2'd0;
    end else if (flush) begin
      r_valid        <= 1'b0;
      r_reg_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_branch_taken <= 1'b0;
      r_kill_cnt     <= 2'd0;
    end else if (stall) begin
      // Drop the pulse so a taken branch is reported exactly once
      r_branch_taken <= 1'b0;
    end else begin
      r_result     <= ex_result;
      r_store_data <= ex_store_data;
      r_rd         <= ex_rd;
      r_valid      <= w_accept;
      r_reg_write  <= ex_reg_write && w_accept;
      r_mem_read   <= ex_mem_read && w_accept;
      r_mem_write  <= ex_mem_write && w_accept;
      if (w_accept && ex_set_flags) begin
        r_flag_z <= ex_zero;
        r_flag_n <= ex_negative;
      end
      r_branch_taken <= w_taken;
      if (w_taken) begin
        r_branch_target <= ex_branch_target;
      end
      if (w_taken) begin
        r_kill_cnt <= KILL_INIT;
      end else if (r_kill_cnt != 2'd0) begin
        r_kill_cnt <= r_kill_cnt - 2'd1;
      end else begin
        r_kill_cnt <= 2'd0;
      end
      if (w_accept && (r_retired != '1)) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  // Registered state drives the outputs directly
  always_comb begin
    mem_valid      = r_valid;
    mem_reg_write  = r_reg_write;
    mem_mem_read   = r_mem_read;
    mem_mem_write  = r_mem_write;
    mem_result     = r_result;
    mem_store_data = r_store_data;
    mem_rd         = r_rd;
    flag_z         = r_flag_z;
    flag_n         = r_flag_n;
    branch_taken   = r_branch_taken;
    branch_target  = r_branch_target;
    retired_count  = r_retired;
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed testbench for alu_result_stage with hand-computed expectations.
module tb_alu_result_stage;

  logic        EN;
  logic        rst_n;
  logic        ex_valid;
  logic [15:0] ex_result;
  logic        ex_zero;
  logic        ex_negative;
  logic [2:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [15:0] ex_store_data;
  logic        ex_set_flags;
  logic        ex_branch;
  logic [1:0]  ex_branch_cond;
  logic [15:0] ex_branch_target;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [15:0] mem_result;
  logic [15:0] mem_store_data;
  logic [2:0]  mem_rd;
  logic        flag_z;
  logic        flag_n;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] retired_count;

  int errors = 0;
  int checks = 0;

  alu_result_stage #(
    .WIDTH(16),
    .REG_ADDR_W(3),
    .KILL_SLOTS(1)
  ) dut (
    .EN(EN),
    .rst_n(rst_n),
    .ex_valid(ex_valid),
    .ex_result(ex_result),
    .ex_zero(ex_zero),
    .ex_negative(ex_negative),
    .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data),
    .ex_set_flags(ex_set_flags),
    .ex_branch(ex_branch),
    .ex_branch_cond(ex_branch_cond),
    .ex_branch_target(ex_branch_target),
    .stall(stall),
    .flush(flush),
    .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write),
    .mem_result(mem_result),
    .mem_store_data(mem_store_data),
    .mem_rd(mem_rd),
    .flag_z(flag_z),
    .flag_n(flag_n),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .retired_count(retired_count)
  );

  initial EN = 1'b0;
  always #5 EN = ~EN;

  // Advance past the next rising edge; outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge EN);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_result = '0; ex_zero = 0; ex_negative = 0; ex_rd = '0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_store_data = '0;
    ex_set_flags = 0; ex_branch = 0; ex_branch_cond = 2'b00;
    ex_branch_target = '0; stall = 0; flush = 0;
  endtask

  task automatic alu_op(input logic [15:0] res, input logic z, input logic n,
                        input logic [2:0] rd, input logic sf);
    idle();
    ex_valid = 1; ex_result = res; ex_zero = z; ex_negative = n;
    ex_rd = rd; ex_reg_write = 1; ex_set_flags = sf;
  endtask

  task automatic br_op(input logic [15:0] res, input logic z, input logic n,
                       input logic [1:0] cond, input logic [15:0] tgt);
    idle();
    ex_valid = 1; ex_result = res; ex_zero = z; ex_negative = n;
    ex_branch = 1; ex_branch_cond = cond; ex_branch_target = tgt;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #2;
    checks++;
    if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_result,
         mem_store_data, mem_rd, flag_z, flag_n, branch_taken, branch_target,
         retired_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b result=%h count=%h taken=%b expected all zero",
               mem_valid, mem_result, retired_count, branch_taken);
    end
    tick();
    rst_n = 1;
  endtask

  task automatic test_load();
    alu_op(16'd117, 0, 0, 3'd3, 1);
    ex_store_data = 16'h5A5A;
    tick();
    checks++;
    if ({mem_result, mem_rd, mem_valid, mem_reg_write, flag_z, flag_n, retired_count}
        !== {16'd117, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL load: result=%0d rd=%0d valid=%b rw=%b z=%b n=%b count=%0d expected 117 3 1 1 0 0 1",
               mem_result, mem_rd, mem_valid, mem_reg_write, flag_z, flag_n, retired_count);
    end
    checks++;
    if ({mem_store_data, branch_taken, mem_mem_read, mem_mem_write} !== {16'h5A5A, 3'b000}) begin
      errors++;
      $display("FAIL load_ctrl: sd=%h taken=%b mr=%b mw=%b expected 5a5a 0 0 0",
               mem_store_data, branch_taken, mem_mem_read, mem_mem_write);
    end
  endtask

  task automatic test_branch_kill();
    br_op(16'd0, 1, 0, 2'b00, 16'h0040);
    ex_set_flags = 1;
    tick();
    checks++;
    if ({branch_taken, branch_target, flag_z, retired_count} !== {1'b1, 16'h0040, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL eq_taken: taken=%b target=%h z=%b count=%0d expected 1 0040 1 2",
               branch_taken, branch_target, flag_z, retired_count);
    end
    alu_op(16'd29, 0, 0, 3'd4, 1);
    ex_mem_write = 1;
    tick();
    checks++;
    if ({branch_taken, mem_valid, mem_reg_write, mem_mem_write, flag_z, retired_count, mem_result}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 16'd29}) begin
      errors++;
      $display("FAIL killed_slot: taken=%b valid=%b rw=%b mw=%b z=%b count=%0d result=%0d expected 0 0 0 0 1 2 29",
               branch_taken, mem_valid, mem_reg_write, mem_mem_write, flag_z, retired_count, mem_result);
    end
    alu_op(16'd30, 0, 0, 3'd5, 1);
    tick();
    checks++;
    if ({mem_valid, flag_z, retired_count, mem_rd} !== {1'b1, 1'b0, 16'd3, 3'd5}) begin
      errors++;
      $display("FAIL after_kill: valid=%b z=%b count=%0d rd=%0d expected 1 0 3 5",
               mem_valid, flag_z, retired_count, mem_rd);
    end
  endtask

  task automatic test_cond();
    br_op(16'd29, 0, 0, 2'b11, 16'h0100);
    tick();
    checks++;
    if ({branch_taken, branch_target, retired_count} !== {1'b1, 16'h0100, 16'd4}) begin
      errors++;
      $display("FAIL gt_taken: taken=%b target=%h count=%0d expected 1 0100 4",
               branch_taken, branch_target, retired_count);
    end
    idle();
    tick();
    checks++;
    if ({branch_taken, mem_valid, retired_count} !== {1'b0, 1'b0, 16'd4}) begin
      errors++;
      $display("FAIL bubble_kill: taken=%b valid=%b count=%0d expected 0 0 4",
               branch_taken, mem_valid, retired_count);
    end
    br_op(16'd29, 0, 1, 2'b11, 16'h0200);
    tick();
    checks++;
    if ({branch_taken, branch_target, mem_valid, retired_count, flag_n}
        !== {1'b0, 16'h0100, 1'b1, 16'd5, 1'b0}) begin
      errors++;
      $display("FAIL gt_not_taken: taken=%b target=%h valid=%b count=%0d n=%b expected 0 0100 1 5 0",
               branch_taken, branch_target, mem_valid, retired_count, flag_n);
    end
    br_op(16'd29, 0, 1, 2'b10, 16'h0300);
    tick();
    checks++;
    if ({branch_taken, branch_target, retired_count} !== {1'b1, 16'h0300, 16'd6}) begin
      errors++;
      $display("FAIL lt_taken: taken=%b target=%h count=%0d expected 1 0300 6",
               branch_taken, branch_target, retired_count);
    end
    br_op(16'd7, 0, 0, 2'b01, 16'h0400);
    tick();
    checks++;
    if ({branch_taken, mem_valid, branch_target, retired_count} !== {1'b0, 1'b0, 16'h0300, 16'd6}) begin
      errors++;
      $display("FAIL killed_branch: taken=%b valid=%b target=%h count=%0d expected 0 0 0300 6",
               branch_taken, mem_valid, branch_target, retired_count);
    end
  endtask

  task automatic test_stall();
    br_op(16'd5, 0, 0, 2'b01, 16'h1234);
    ex_rd = 3'd2;
    tick();
    checks++;
    if ({branch_taken, branch_target, retired_count} !== {1'b1, 16'h1234, 16'd7}) begin
      errors++;
      $display("FAIL ne_taken: taken=%b target=%h count=%0d expected 1 1234 7",
               branch_taken, branch_target, retired_count);
    end
    alu_op(16'd99, 0, 0, 3'd6, 1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({branch_taken, mem_result, mem_rd, mem_valid, branch_target, retired_count}
          !== {1'b0, 16'd5, 3'd2, 1'b1, 16'h1234, 16'd7}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: taken=%b result=%0d rd=%0d valid=%b target=%h count=%0d expected 0 5 2 1 1234 7",
                 i, branch_taken, mem_result, mem_rd, mem_valid, branch_target, retired_count);
      end
    end
    stall = 0;
    tick();
    checks++;
    if ({mem_valid, mem_result, retired_count} !== {1'b0, 16'd99, 16'd7}) begin
      errors++;
      $display("FAIL kill_after_stall: valid=%b result=%0d count=%0d expected 0 99 7",
               mem_valid, mem_result, retired_count);
    end
    tick();
    checks++;
    if ({mem_valid, retired_count} !== {1'b1, 16'd8}) begin
      errors++;
      $display("FAIL accept_after_stall: valid=%b count=%0d expected 1 8",
               mem_valid, retired_count);
    end
  endtask

  task automatic test_flush_stall();
    br_op(16'd0, 1, 0, 2'b00, 16'h0ABC);
    tick();
    checks++;
    if ({branch_taken, retired_count} !== {1'b1, 16'd9}) begin
      errors++;
      $display("FAIL flush_setup: taken=%b count=%0d expected 1 9", branch_taken, retired_count);
    end
    alu_op(16'd77, 0, 0, 3'd1, 1);
    ex_mem_read = 1;
    flush = 1;
    stall = 1;
    tick();
    checks++;
    if ({mem_valid, mem_reg_write, mem_mem_read, branch_taken, mem_result, branch_target, retired_count}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'h0ABC, 16'd9}) begin
      errors++;
      $display("FAIL flush_stall: valid=%b rw=%b mr=%b taken=%b result=%0d target=%h count=%0d expected 0 0 0 0 0 0abc 9",
               mem_valid, mem_reg_write, mem_mem_read, branch_taken, mem_result, branch_target, retired_count);
    end
    flush = 0;
    stall = 0;
    ex_result = 16'd55;
    tick();
    checks++;
    if ({mem_valid, mem_mem_read, mem_result, retired_count} !== {1'b1, 1'b1, 16'd55, 16'd10}) begin
      errors++;
      $display("FAIL after_flush: valid=%b mr=%b result=%0d count=%0d expected 1 1 55 10",
               mem_valid, mem_mem_read, mem_result, retired_count);
    end
  endtask

  task automatic test_async_reset();
    br_op(16'd0, 1, 0, 2'b00, 16'h0077);
    tick();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_result,
         mem_store_data, mem_rd, flag_z, flag_n, branch_taken, branch_target,
         retired_count} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b taken=%b target=%h count=%0d expected all zero",
               mem_valid, branch_taken, branch_target, retired_count);
    end
    @(negedge EN);
    rst_n = 1;
    alu_op(16'd12, 0, 0, 3'd7, 0);
    tick();
    checks++;
    if ({mem_valid, mem_result, retired_count} !== {1'b1, 16'd12, 16'd1}) begin
      errors++;
      $display("FAIL accept_after_reset: valid=%b result=%0d count=%0d expected 1 12 1",
               mem_valid, mem_result, retired_count);
    end
  endtask

  task automatic test_saturation();
    // Count is 1 on entry; 65533 more accepts reach FFFE
    alu_op(16'd1, 0, 0, 3'd1, 0);
    for (int i = 0; i < 65533; i++) tick();
    checks++;
    if (retired_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preset: count=%h expected fffe", retired_count);
    end
    tick();
    checks++;
    if (retired_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_first: count=%h expected ffff", retired_count);
    end
    tick();
    checks++;
    if (retired_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: count=%h expected ffff", retired_count);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_branch_kill();
    test_cond();
    test_stall();
    test_flush_stall();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
